// File: rtl/min_distance_select.sv
// Streaming arg-min over N distances: reports the lowest-index smallest value
// with a valid/ready handshake and supports back-to-back searches.
module min_distance_select #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IDX_WIDTH-1:0]  num_centroids,
  input  logic                  dist_valid,
  input  logic [DATA_WIDTH-1:0] dist_in,
  output logic                  busy,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [IDX_WIDTH-1:0]  min_index,
  output logic [DATA_WIDTH-1:0] min_distance
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [IDX_WIDTH-1:0]  r_n;
  logic [IDX_WIDTH-1:0]  r_count;
  logic [DATA_WIDTH-1:0] r_best;
  logic [IDX_WIDTH-1:0]  r_best_idx;
  logic [IDX_WIDTH-1:0]  r_min_index;
  logic [DATA_WIDTH-1:0] r_min_distance;

  logic                  w_start_ok;
  logic                  w_load;
  logic                  w_sample;
  logic                  w_last;
  logic                  w_take;
  logic [DATA_WIDTH-1:0] w_best_next;
  logic [IDX_WIDTH-1:0]  w_idx_next;

  assign w_start_ok  = start && (num_centroids != {IDX_WIDTH{1'b0}});
  assign w_sample    = (r_state == S_COLLECT) && dist_valid;
  assign w_last      = w_sample && (r_count == (r_n - {{(IDX_WIDTH-1){1'b0}}, 1'b1}));
  // Strict less-than keeps the earlier index on ties.
  assign w_take      = dist_in < r_best;
  assign w_best_next = w_take ? dist_in : r_best;
  assign w_idx_next  = w_take ? r_count : r_best_idx;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a search may be started in IDLE or on the HOLD handshake.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_state_next = S_COLLECT;
          w_load       = 1'b1;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_COLLECT: begin
        if (w_last) begin
          w_state_next = S_HOLD;
        end else begin
          w_state_next = S_COLLECT;
        end
      end
      S_HOLD: begin
        if (result_ready && w_start_ok) begin
          w_state_next = S_COLLECT;
          w_load       = 1'b1;
        end else if (result_ready) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_HOLD;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Search datapath: running best and the sample counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_n        <= {IDX_WIDTH{1'b0}};
      r_count    <= {IDX_WIDTH{1'b0}};
      r_best     <= {DATA_WIDTH{1'b1}};
      r_best_idx <= {IDX_WIDTH{1'b0}};
    end else if (w_load) begin
      r_n        <= num_centroids;
      r_count    <= {IDX_WIDTH{1'b0}};
      r_best     <= {DATA_WIDTH{1'b1}};
      r_best_idx <= {IDX_WIDTH{1'b0}};
    end else if (w_sample) begin
      r_count    <= r_count + {{(IDX_WIDTH-1){1'b0}}, 1'b1};
      r_best     <= w_best_next;
      r_best_idx <= w_idx_next;
    end
  end

  // Result registers capture the final best, including the last sample, on entry to HOLD.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_min_index    <= {IDX_WIDTH{1'b0}};
      r_min_distance <= {DATA_WIDTH{1'b0}};
    end else if (w_last) begin
      r_min_index    <= w_idx_next;
      r_min_distance <= w_best_next;
    end
  end

  assign busy         = (r_state == S_COLLECT);
  assign result_valid = (r_state == S_HOLD);
  assign min_index    = r_min_index;
  assign min_distance = r_min_distance;

endmodule

// File: tb/tb_min_distance_select.sv
// Directed self-checking bench for min_distance_select; expected values are
// hand-computed from the stimulus.
module tb_min_distance_select;

  localparam int DW = 32;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [IW-1:0] num_centroids;
  logic          dist_valid;
  logic [DW-1:0] dist_in;
  logic          busy;
  logic          result_valid;
  logic          result_ready;
  logic [IW-1:0] min_index;
  logic [DW-1:0] min_distance;

  int errors = 0;
  int checks = 0;

  min_distance_select #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .num_centroids (num_centroids),
    .dist_valid    (dist_valid),
    .dist_in       (dist_in),
    .busy          (busy),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .min_index     (min_index),
    .min_distance  (min_distance)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_search(input logic [IW-1:0] n);
    start = 1'b1;
    num_centroids = n;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d);
    dist_valid = 1'b1;
    dist_in = d;
    step();
    dist_valid = 1'b0;
    dist_in = 32'h0;
  endtask

  task automatic expect_result(input string tag, input logic [IW-1:0] idx, input logic [DW-1:0] d);
    check({tag, "_rv"},   result_valid, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_idx"},  min_index, idx);
    check({tag, "_dist"}, min_distance, d);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    num_centroids = 8'd0;
    dist_valid = 1'b0;
    dist_in = 32'h0;
    result_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_rv",   result_valid, 1'b0);
    check("rst_idx",  min_index, 8'd0);
    check("rst_dist", min_distance, 32'd0);

    // N=4: 9,3,7,5 back-to-back
    begin_search(8'd4);
    check("t1_busy", busy, 1'b1);
    send(32'd9);
    send(32'd3);
    send(32'd7);
    check("t1_rv_early", result_valid, 1'b0);
    send(32'd5);
    expect_result("t1", 8'd1, 32'd3);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check("t1_idle_rv",  result_valid, 1'b0);
    check("t1_idle_idx", min_index, 8'd1);

    // N=3: 6,2,2 with two-cycle gaps; tie keeps the lower index
    begin_search(8'd3);
    send(32'd6);
    step(); step();
    check("t2_gap_busy", busy, 1'b1);
    check("t2_gap_hold", min_distance, 32'd3);
    send(32'd2);
    step(); step();
    send(32'd2);
    expect_result("t2", 8'd1, 32'd2);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;

    // N=1 all-ones sample, consumer stalls for 5 cycles
    begin_search(8'd1);
    send(32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      expect_result($sformatf("t3_stall%0d", i), 8'd0, 32'hFFFF_FFFF);
      step();
    end
    expect_result("t3_end", 8'd0, 32'hFFFF_FFFF);

    // Handshake and restart in the same cycle: no IDLE cycle between searches
    result_ready = 1'b1;
    begin_search(8'd2);
    result_ready = 1'b0;
    check("t4_b2b_busy", busy, 1'b1);
    check("t4_b2b_rv",   result_valid, 1'b0);
    send(32'd4);
    send(32'd1);
    expect_result("t4", 8'd1, 32'd1);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;

    // Reset mid-search, with competing inputs, discards the partial result
    begin_search(8'd4);
    send(32'd1);
    send(32'd2);
    reset = 1'b1;
    start = 1'b1;
    num_centroids = 8'd2;
    dist_valid = 1'b1;
    dist_in = 32'd0;
    step();
    reset = 1'b0;
    start = 1'b0;
    dist_valid = 1'b0;
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_rv",   result_valid, 1'b0);
    check("t5_rst_dist", min_distance, 32'd0);
    begin_search(8'd2);
    send(32'd8);
    send(32'd8);
    expect_result("t5", 8'd0, 32'd8);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;

    // start with N=0 is ignored
    begin_search(8'd0);
    check("t6_busy", busy, 1'b0);
    dist_valid = 1'b1;
    dist_in = 32'd0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t6_rv%0d", i), result_valid, 1'b0);
      check($sformatf("t6_busy%0d", i), busy, 1'b0);
    end
    dist_valid = 1'b0;
    check("t6_hold_dist", min_distance, 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/min_distance_select.md
MIN_DISTANCE_SELECT -- requirements
Module: min_distance_select

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of distance samples and result distance.
REQ-002 SHALL have parameter IDX_WIDTH, default 8, width of centroid count and index.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  begin a new search; sampled only in IDLE, or in HOLD on the completing handshake cycle.
REQ-006 SHALL have port num_centroids  input  IDX_WIDTH  number of distances in the search; sampled when start is accepted.
REQ-007 SHALL have port dist_valid  input  1  dist_in carries a valid distance this cycle.
REQ-008 SHALL have port dist_in  input  DATA_WIDTH  unsigned distance from the upstream accumulator, centroids in order 0..N-1.
REQ-009 SHALL have port busy  output  1  high in COLLECT.
REQ-010 SHALL have port result_valid  output  1  high in HOLD.
REQ-011 SHALL have port result_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port min_index  output  IDX_WIDTH  index of the smallest distance.
REQ-013 SHALL have port min_distance  output  DATA_WIDTH  smallest distance value.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, COLLECT, HOLD.
REQ-015 IDLE: start=1 and num_centroids!=0 -> latch N, count=0, best=all-ones, best_idx=0, go to COLLECT.
REQ-016 IDLE: start=1 with num_centroids=0 -> ignored, remain IDLE.
REQ-017 COLLECT: each cycle with dist_valid=1 -> compare unsigned; if dist_in < best, best=dist_in, best_idx=count; count increments by 1.
REQ-018 COLLECT: cycles with dist_valid=0 -> no state change (gaps allowed, no timeout).
REQ-019 Ties: strict less-than only; lowest index wins among equal distances.
REQ-020 COLLECT: dist_valid=1 with count==N-1 -> go to HOLD; result_valid high the next cycle (1-cycle latency from last sample), result reflecting that sample.
REQ-021 COLLECT: start ignored; dist_valid in IDLE and HOLD ignored.
REQ-022 HOLD: min_index and min_distance stable while result_valid=1 and result_ready=0.
REQ-023 HOLD: result_ready=1 -> result consumed; next state IDLE, unless start=1 with num_centroids!=0 in the same cycle, then COLLECT directly (back-to-back, counters reinitialised per REQ-015).
REQ-024 min_index/min_distance hold last result in IDLE and COLLECT; updated only on entering HOLD.
REQ-025 Count and compare SHALL not wrap: N up to 2^IDX_WIDTH-1 supported; count width IDX_WIDTH.
REQ-026 Distance all-ones as sole/min sample SHALL still be reported with its correct index (best initialised all-ones, best_idx=0 covers index 0 case; later all-ones samples do not replace).

Reset
REQ-027 reset=1 SHALL force IDLE in the next cycle regardless of state, including mid-COLLECT and HOLD; any partial search discarded.
REQ-028 Reset values: busy=0, result_valid=0, min_index=0, min_distance=0, count=0, best=all-ones, best_idx=0.
REQ-029 reset SHALL take priority over start, dist_valid and result_ready in the same cycle.

Verification
REQ-030 start, N=4, distances 9,3,7,5 consecutive -> result_valid 1 cycle after 4th sample, min_index=1, min_distance=3.
REQ-031 N=3, distances 6,2,2 with dist_valid gaps of 2 cycles -> min_index=1, min_distance=2 (tie keeps lower index).
REQ-032 N=1, distance 0xFFFFFFFF -> min_index=0, min_distance=0xFFFFFFFF; result_ready held low 5 cycles -> outputs stable, result_valid stays 1.
REQ-033 HOLD with result_ready=1 and start=1, N=2, then distances 4,1 -> no IDLE cycle, second result min_index=1, min_distance=1.
REQ-034 reset asserted after 2 of 4 samples -> busy=0, result_valid=0 next cycle; new search N=2 (8,8) -> min_index=0, min_distance=8.
REQ-035 start with num_centroids=0 -> stays IDLE, busy=0, result_valid never asserts.
